uart_frame_collector: RTL and testbench
=======================================

Name: uart_frame_collector

Overview:
- Host-side counterpart of the sample-streaming UART transmitter.
- Issues the start command (0xFF) and the stop command (0x00) over a byte-level UART TX interface.
- Receives the R/I sample byte stream, reassembles it into 32-bit words and writes them into a sample RAM.
- Sits between the shared UART byte RX/TX cores and the capture buffer. It lets one board drive and collect a remote acquisition front end.

Parameters:
- ADDR_W, 16, width of the RAM write address and of PULSE_LEN.
- TIMEOUT_CYC, 50000, maximum CLOCK_50M cycles allowed between bytes inside a frame (about 1 ms).
- CNT_W, 16, width of the frame counters.

Ports:
- CLOCK_50M  in  1  system clock; the only clock.
- RESET  in  1  asynchronous, active-high reset.
- CMD_START  in  1  one-cycle pulse; begin a session.
- CMD_STOP  in  1  one-cycle pulse; end the session after the current frame.
- PULSE_LEN  in  ADDR_W  words per frame; sampled at CMD_START.
- FRAMES  in  CNT_W  frames per session; 0 means unlimited; sampled at CMD_START.
- RX_DATA  in  8  received byte from the UART RX core.
- RX_VALID  in  1  one-cycle strobe; RX_DATA is valid.
- TX_DATA  out  8  byte to transmit.
- TX_WR  out  1  one-cycle write strobe to the UART TX core.
- TX_IDLE  in  1  high when the TX core can accept a byte.
- WADDR  out  ADDR_W  RAM word address.
- WDATA  out  32  RAM word {I[15:0], R[15:0]}.
- WE  out  1  RAM write strobe.
- FRAME_DONE  out  1  one-cycle pulse; a frame is complete.
- FRAME_CNT  out  CNT_W  number of completed frames in this session.
- BUSY  out  1  high from accepted CMD_START until the stop byte is handed to TX.
- ERR  out  1  one-cycle pulse on timeout or on a rejected start.

Behaviour:
- Reset values: every output is 0. State returns to IDLE and all counters clear. Reset mid-session aborts with no stop byte sent.
- States:
  - IDLE
  - SEND_START
  - RECV
  - SEND_STOP
  - TX_GAP (shared by both send paths)
- IDLE:
  - CMD_START with PULSE_LEN≠0: latch PULSE_LEN and FRAMES, clear FRAME_CNT and the word/byte indices, set BUSY, go to SEND_START.
  - CMD_START with PULSE_LEN=0: pulse ERR, stay in IDLE.
  - CMD_STOP: ignored.
- SEND_START / SEND_STOP:
  - Wait for TX_IDLE=1, then put TX_DATA on the bus and pulse TX_WR for one cycle.
  - TX_DATA stays stable from that cycle until the next TX_WR.
  - TX_GAP then holds 2 cycles, ignoring TX_IDLE (the TX core lags).
  - After the start byte, go to RECV. After the stop byte, clear BUSY and go to IDLE.
- RECV byte order within each word:
  - byte0 → R[15:8]
  - byte1 → R[7:0]
  - byte2 → I[15:8]
  - byte3 → I[7:0]
- Word write: on the RX_VALID carrying byte3, WE=1 in the next cycle with WADDR = word index and WDATA = {I,R}. The word index then increments.
- Frame end: when the written word index equals PULSE_LEN-1, in the same cycle as that WE:
  - pulse FRAME_DONE;
  - increment FRAME_CNT (saturating at its maximum);
  - reset the word index to 0.
- Session end, evaluated on the FRAME_DONE cycle: if CMD_STOP is pending, or FRAMES≠0 and the new FRAME_CNT equals FRAMES, go to SEND_STOP. Otherwise stay in RECV.
- CMD_STOP during RECV is latched as pending; the current frame always completes first.
- CMD_STOP and the last-byte RX_VALID in the same cycle: the stop is honoured at the end of that frame.
- Timeout:
  - The timeout counter starts at the first byte of a frame and reloads on every RX_VALID.
  - If it reaches TIMEOUT_CYC mid-frame: pulse ERR, discard the partial word, reset the word and byte indices to 0, and stay in RECV. FRAME_CNT is unchanged.
  - Words of the partial frame already written remain in RAM.
- No timeout applies while waiting for the first byte of a frame.
- RX_VALID outside RECV is ignored.
- CMD_START while BUSY is ignored.

Decomposition:
- Shared package holds:
  - state enum;
  - CMD_START_BYTE = 8'hFF;
  - CMD_STOP_BYTE = 8'h00;
  - BYTES_PER_WORD = 4.
- One sub-module, rx_word_packer: 2-bit byte index, 32-bit shift/assembly register, word_valid pulse, and a synchronous clear used by the timeout and session start.
- The top level holds the FSM, TX handshake, counters and timeout.

Test Plan:
- Start handshake: PULSE_LEN=4, FRAMES=1, CMD_START, TX_IDLE=1 → TX_WR pulses once with TX_DATA=0xFF, and BUSY=1.
- Word assembly: bytes 12 34 56 78 → WE with WADDR=0 and WDATA=0x56781234.
- Full frame and stop: 16 bytes → WADDR 0..3 written; FRAME_DONE pulses with the fourth WE; FRAME_CNT=1; TX_WR with TX_DATA=0x00; BUSY drops.
- Timeout: FRAMES=0, send 3 bytes then idle 50000 cycles → ERR pulses, no WE. Then send 4 bytes → WE with WADDR=0 and a correctly aligned word.
- Pending stop: FRAMES=0, CMD_STOP after word 1 of frame 2 → frame 2 completes, FRAME_CNT=2, then 0x00 is sent. Also check CMD_STOP coincident with the final byte.
- Rejects and reset: CMD_START with PULSE_LEN=0 → ERR pulse, no TX_WR. RESET asserted mid-RECV → all outputs 0 immediately and no stop byte sent.

Source files
------------

// File: rtl/uart_frame_collector_pkg.sv
// Shared types and constants for the UART frame collector: FSM encoding,
// command bytes and word geometry.
package uart_frame_collector_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SEND_START = 3'd1,
    ST_RECV       = 3'd2,
    ST_SEND_STOP  = 3'd3,
    ST_TX_GAP     = 3'd4
  } state_t;

  localparam logic [7:0] CMD_START_BYTE = 8'hFF;
  localparam logic [7:0] CMD_STOP_BYTE  = 8'h00;
  localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_frame_collector_rx_word_packer.sv
// Packs four received bytes into one {I[15:0], R[15:0]} word; the word
// strobe is registered so it appears the cycle after the fourth byte.
module uart_frame_collector_rx_word_packer
  import uart_frame_collector_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_byte_idx;
  logic [23:0] r_shift;
  logic [31:0] r_word;
  logic        r_word_valid;
  logic        w_last_byte;

  assign w_last_byte = (r_byte_idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_idx   <= '0;
      r_shift      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_byte_idx <= '0;
        r_shift    <= '0;
      end else if (i_byte_valid) begin
        r_shift    <= {r_shift[15:0], i_byte};
        r_byte_idx <= r_byte_idx + 2'd1;
        if (w_last_byte) begin
          // r_shift holds {b0, b1, b2}; reorder into {b2, b3, b0, b1}
          r_word       <= {r_shift[7:0], i_byte, r_shift[23:8]};
          r_word_valid <= 1'b1;
        end
      end
    end
  end

  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

endmodule

// File: rtl/uart_frame_collector.sv
// Host-side session controller: sends start/stop command bytes, collects
// the R/I sample byte stream into 32-bit RAM words and counts frames.
module uart_frame_collector
  import uart_frame_collector_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 16
) (
  input  logic              CLOCK_50M,
  input  logic              RESET,
  input  logic              CMD_START,
  input  logic              CMD_STOP,
  input  logic [ADDR_W-1:0] PULSE_LEN,
  input  logic [CNT_W-1:0]  FRAMES,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic [7:0]        TX_DATA,
  output logic              TX_WR,
  input  logic              TX_IDLE,
  output logic [ADDR_W-1:0] WADDR,
  output logic [31:0]       WDATA,
  output logic              WE,
  output logic              FRAME_DONE,
  output logic [CNT_W-1:0]  FRAME_CNT,
  output logic              BUSY,
  output logic              ERR,
  output logic [2:0]        o_dbg_state
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_len, r_word_idx;
  logic [CNT_W-1:0]  r_frames, r_frame_cnt, w_cnt_next;
  logic [TO_W-1:0]   r_to_cnt;
  logic [7:0]        r_tx_data;
  logic              r_tx_wr, r_busy, r_err, r_stop_pend;
  logic              r_gap_cnt, r_gap_to_idle, r_in_frame;
  logic              w_start_ok, w_start_bad, w_rx, w_timeout, w_clear;
  logic              w_we, w_last, w_end, w_send;
  logic [31:0]       w_word;

  assign w_start_ok  = (r_state == ST_IDLE) && CMD_START && (PULSE_LEN != '0);
  assign w_start_bad = (r_state == ST_IDLE) && CMD_START && (PULSE_LEN == '0);
  assign w_rx        = (r_state == ST_RECV) && RX_VALID;
  // Silence only counts once a frame has begun; a fresh byte always wins.
  assign w_timeout   = (r_state == ST_RECV) && r_in_frame && !RX_VALID &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign w_clear     = w_start_ok || w_timeout;
  assign w_send      = ((r_state == ST_SEND_START) || (r_state == ST_SEND_STOP)) && TX_IDLE;

  uart_frame_collector_rx_word_packer u_packer (
    .clk          (CLOCK_50M),
    .rst          (RESET),
    .i_clear      (w_clear),
    .i_byte_valid (w_rx),
    .i_byte       (RX_DATA),
    .o_word_valid (w_we),
    .o_word       (w_word)
  );

  assign w_last     = w_we && (r_word_idx == r_len - ADDR_W'(1));
  assign w_cnt_next = (&r_frame_cnt) ? r_frame_cnt : r_frame_cnt + CNT_W'(1);
  assign w_end      = w_last && (r_stop_pend || CMD_STOP ||
                      ((r_frames != '0) && (w_cnt_next == r_frames)));

  always_ff @(posedge CLOCK_50M or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:       if (w_start_ok) w_next = ST_SEND_START;
      ST_SEND_START,
      ST_SEND_STOP:  if (TX_IDLE) w_next = ST_TX_GAP;
      ST_RECV:       if (w_end) w_next = ST_SEND_STOP;
      ST_TX_GAP:     if (r_gap_cnt) w_next = r_gap_to_idle ? ST_IDLE : ST_RECV;
      default:       w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50M or posedge RESET) begin
    if (RESET) begin
      r_len         <= '0;
      r_frames      <= '0;
      r_word_idx    <= '0;
      r_frame_cnt   <= '0;
      r_to_cnt      <= '0;
      r_tx_data     <= '0;
      r_tx_wr       <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
      r_stop_pend   <= 1'b0;
      r_gap_cnt     <= 1'b0;
      r_gap_to_idle <= 1'b0;
      r_in_frame    <= 1'b0;
    end else begin
      r_tx_wr   <= 1'b0;
      r_err     <= w_start_bad || w_timeout;
      r_gap_cnt <= (r_state == ST_TX_GAP) && !r_gap_cnt;

      if (w_send) begin
        r_tx_wr       <= 1'b1;
        r_tx_data     <= (r_state == ST_SEND_STOP) ? CMD_STOP_BYTE : CMD_START_BYTE;
        r_gap_to_idle <= (r_state == ST_SEND_STOP);
      end

      if (w_start_ok) begin
        r_len       <= PULSE_LEN;
        r_frames    <= FRAMES;
        r_busy      <= 1'b1;
        r_frame_cnt <= '0;
        r_word_idx  <= '0;
        r_stop_pend <= 1'b0;
        r_in_frame  <= 1'b0;
        r_to_cnt    <= '0;
      end else begin
        if ((r_state == ST_TX_GAP) && r_gap_cnt && r_gap_to_idle) r_busy <= 1'b0;

        if (r_state == ST_SEND_STOP)  r_stop_pend <= 1'b0;
        else if (r_busy && CMD_STOP)  r_stop_pend <= 1'b1;

        if (w_we) begin
          if (w_last) begin
            r_word_idx  <= '0;
            r_frame_cnt <= w_cnt_next;
          end else begin
            r_word_idx <= r_word_idx + ADDR_W'(1);
          end
        end

        if (w_timeout) begin
          r_word_idx <= '0;
          r_in_frame <= 1'b0;
        end else if (w_rx) begin
          r_in_frame <= 1'b1;
        end else if (w_last) begin
          r_in_frame <= 1'b0;
        end

        if (w_rx || !r_in_frame || w_timeout) r_to_cnt <= '0;
        else                                  r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  assign TX_DATA     = r_tx_data;
  assign TX_WR       = r_tx_wr;
  assign WADDR       = r_word_idx;
  assign WDATA       = w_word;
  assign WE          = w_we;
  assign FRAME_DONE  = w_last;
  assign FRAME_CNT   = r_frame_cnt;
  assign BUSY        = r_busy;
  assign ERR         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_frame_collector.sv
// Scoreboard bench for uart_frame_collector: drivers push expected RAM
// writes, TX bytes, frame counts and errors; a monitor pops and compares.
module tb_uart_frame_collector;

  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;
  localparam int TO_CYC = 300;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_start, cmd_stop, rx_valid, tx_idle;
  logic [ADDR_W-1:0] pulse_len;
  logic [CNT_W-1:0]  frames;
  logic [7:0]        rx_data;
  logic [7:0]        tx_data;
  logic              tx_wr, we, frame_done, busy, err;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic [CNT_W-1:0]  frame_cnt;
  logic [2:0]        dbg_state;

  uart_frame_collector #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC), .CNT_W(CNT_W)) dut (
    .CLOCK_50M(clk), .RESET(rst), .CMD_START(cmd_start), .CMD_STOP(cmd_stop),
    .PULSE_LEN(pulse_len), .FRAMES(frames), .RX_DATA(rx_data), .RX_VALID(rx_valid),
    .TX_DATA(tx_data), .TX_WR(tx_wr), .TX_IDLE(tx_idle), .WADDR(waddr),
    .WDATA(wdata), .WE(we), .FRAME_DONE(frame_done), .FRAME_CNT(frame_cnt),
    .BUSY(busy), .ERR(err), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [47:0]      exp_we_q[$];
  logic [7:0]       exp_tx_q[$];
  logic [CNT_W-1:0] exp_done_q[$];
  int               exp_err_n = 0;

  // reference model of the session
  bit          m_active = 0, m_stop = 0;
  int          m_len, m_frames, m_cnt, m_word;
  logic [7:0]  m_part[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    tests++;
    fails++;
    $display("FAIL %s: unexpected event, value %0h, expected no event", name, act);
  endtask

  // TX core model: goes busy for a random time after each write
  initial begin
    tx_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_wr === 1'b1) begin
        tx_idle = 1'b0;
        repeat ($urandom_range(2, 10)) @(negedge clk);
        tx_idle = 1'b1;
      end
    end
  end

  // monitor / scoreboard
  logic [47:0]      mon_e;
  logic [CNT_W-1:0] cnt_exp;
  bit               cnt_chk = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (cnt_chk) begin
          check("frame_cnt", 64'(frame_cnt), 64'(cnt_exp));
          cnt_chk = 0;
        end
        if (we === 1'b1) begin
          if (exp_we_q.size() == 0) unexpected("we", 64'(wdata));
          else begin
            mon_e = exp_we_q.pop_front();
            check("we_addr", 64'(waddr), 64'(mon_e[47:32]));
            check("we_data", 64'(wdata), 64'(mon_e[31:0]));
          end
        end
        if (frame_done === 1'b1) begin
          if (exp_done_q.size() == 0) unexpected("frame_done", 64'(waddr));
          else begin
            cnt_exp = exp_done_q.pop_front();
            cnt_chk = 1;
          end
        end
        if (tx_wr === 1'b1) begin
          if (exp_tx_q.size() == 0) unexpected("tx_wr", 64'(tx_data));
          else check("tx_data", 64'(tx_data), 64'(exp_tx_q.pop_front()));
        end
        if (err === 1'b1) begin
          if (exp_err_n == 0) unexpected("err", 64'(1));
          else begin
            check("err", 64'(err), 64'(1));
            exp_err_n--;
          end
        end
      end
    end
  end

  // driver tasks, each updating the reference model
  task automatic do_start(input int len, input int fr);
    @(negedge clk);
    pulse_len = ADDR_W'(len);
    frames    = CNT_W'(fr);
    cmd_start = 1'b1;
    if (!m_active) begin
      if (len == 0) exp_err_n++;
      else begin
        m_active = 1; m_stop = 0; m_len = len; m_frames = fr;
        m_cnt = 0; m_word = 0; m_part.delete();
        exp_tx_q.push_back(8'hFF);
      end
    end
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] w;
    if (!m_active) return;
    m_part.push_back(b);
    if (m_part.size() == 4) begin
      w = {m_part[2], m_part[3], m_part[0], m_part[1]};
      m_part.delete();
      exp_we_q.push_back({16'(m_word), w});
      if (m_word == m_len - 1) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        exp_done_q.push_back(CNT_W'(m_cnt));
        m_word = 0;
        if (m_stop || (m_frames != 0 && m_cnt == m_frames)) begin
          exp_tx_q.push_back(8'h00);
          m_active = 0;
        end
      end else begin
        m_word++;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_stop);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    cmd_stop = with_stop;
    if (with_stop && m_active) m_stop = 1;
    model_byte(b);
    @(negedge clk);
    rx_valid = 1'b0;
    cmd_stop = 1'b0;
    repeat ($urandom_range(0, 15)) @(negedge clk);
  endtask

  task automatic send_random(input int n, input bit stop_on_last);
    for (int i = 0; i < n; i++)
      send_byte(8'($urandom_range(0, 255)), stop_on_last && (i == n - 1));
  endtask

  task automatic send_stop();
    @(negedge clk);
    cmd_stop = 1'b1;
    if (m_active) m_stop = 1;
    @(negedge clk);
    cmd_stop = 1'b0;
  endtask

  task automatic idle_timeout();
    if (m_active && (m_part.size() != 0 || m_word != 0)) begin
      exp_err_n++;
      m_part.delete();
      m_word = 0;
    end
    repeat (TO_CYC + 20) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp_tx_q.size() != 0 || exp_we_q.size() != 0 || exp_done_q.size() != 0 ||
            exp_err_n != 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      tests++;
      fails++;
      $display("FAIL %s_wait: expected events not seen within 3000 cycles", name);
    end
    repeat (6) @(negedge clk);
    check({name, "_busy"}, 64'(busy), 64'(m_active));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tx_data"}, 64'(tx_data), 0);
    check({name, "_tx_wr"}, 64'(tx_wr), 0);
    check({name, "_waddr"}, 64'(waddr), 0);
    check({name, "_wdata"}, 64'(wdata), 0);
    check({name, "_we"}, 64'(we), 0);
    check({name, "_frame_done"}, 64'(frame_done), 0);
    check({name, "_frame_cnt"}, 64'(frame_cnt), 0);
    check({name, "_busy"}, 64'(busy), 0);
    check({name, "_err"}, 64'(err), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_start = 0; cmd_stop = 0; rx_valid = 0; rx_data = 0;
    pulse_len = 0; frames = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // start handshake, word assembly, full frame and stop
    do_start(4, 1);
    drain("start");
    send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
    send_random(12, 0);
    drain("frame_stop");

    // rejected start
    do_start(0, 5);
    drain("reject");

    // timeout mid-word, then a realigned word, stop on the final byte
    do_start(3, 0);
    drain("to_start");
    send_random(3, 0);
    idle_timeout();
    send_byte(8'hA1, 0); send_byte(8'hB2, 0); send_byte(8'hC3, 0); send_byte(8'hD4, 0);
    send_random(8, 1);
    drain("to_stop");

    // timeout on a word boundary inside a frame
    do_start(3, 0);
    drain("to2_start");
    send_random(4, 0);
    idle_timeout();
    send_random(12, 1);
    drain("to2_stop");

    // pending stop in frame 2, with an ignored start while busy
    do_start(2, 0);
    drain("pend_start");
    send_random(8, 0);
    send_random(4, 0);
    send_stop();
    do_start(5, 1);
    send_random(4, 0);
    drain("pend_stop");

    // randomized sessions
    for (int s = 0; s < 4; s++) begin
      int len, fr;
      len = $urandom_range(1, 5);
      fr  = $urandom_range(1, 3);
      do_start(len, fr);
      drain("rnd_start");
      send_random(len * fr * 4, 0);
      drain("rnd_stop");
    end

    // reset in the middle of a session
    do_start(2, 0);
    drain("rst_start");
    send_random(10, 0);
    drain("rst_pre");
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_reset");
    m_active = 0; m_stop = 0; m_part.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("post_reset_busy", 64'(busy), 0);

    // operation after reset
    do_start(1, 1);
    drain("post_start");
    send_random(4, 0);
    drain("post_stop");

    check("leftover_we", 64'(exp_we_q.size()), 0);
    check("leftover_tx", 64'(exp_tx_q.size()), 0);
    check("leftover_done", 64'(exp_done_q.size()), 0);
    check("leftover_err", 64'(exp_err_n), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
